// File: rtl/fifo_pkg.sv
// Gray/binary conversion helpers shared by the read- and write-side pointer blocks.
// Operands are zero-extended into a 32-bit word; callers cast back to their own width.
package fifo_pkg;

    localparam int unsigned GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero upper bits leave narrower codes unaffected.
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b = '0;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/read_ptr_if.sv
// Read-side pointer bus: pop request and synchronised write pointer in, pointers and flags out.
interface read_ptr_if #(
    parameter int unsigned ptr_width = 8
);
    localparam int unsigned PW = ptr_width + 1;

    logic          r_en;
    logic [PW-1:0] wptr_sync;
    logic [PW-1:0] raddr;
    logic [PW-1:0] rptr;
    logic          empty;
    logic          almost_empty;
    logic [PW-1:0] rcount;
    logic          rvalid;
    logic          underflow;

    modport master (
        output r_en, wptr_sync,
        input  raddr, rptr, empty, almost_empty, rcount, rvalid, underflow
    );

    modport slave (
        input  r_en, wptr_sync,
        output raddr, rptr, empty, almost_empty, rcount, rvalid, underflow
    );
endinterface

// File: rtl/read_ptr.sv
// Async FIFO read-domain pointer and flag controller: binary/Gray read pointer,
// empty/almost_empty, occupancy, read-data-valid strobe and sticky underflow.
module read_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned ptr_width = 8,
    parameter int unsigned AE_THRESH = 4
) (
    input  logic     rclk,
    input  logic     r_rst_n,
    read_ptr_if.slave bus
);
    localparam int unsigned PW = ptr_width + 1;

    logic [PW-1:0] raddr;
    logic [PW-1:0] rptr;
    logic          empty;
    logic          almost_empty;
    logic [PW-1:0] rcount;
    logic          rvalid;
    logic          underflow;

    logic          pop_c;
    logic [PW-1:0] raddr_next_c;
    logic [PW-1:0] rptr_next_c;
    logic [PW-1:0] wbin_c;
    logic [PW-1:0] rcount_next_c;
    logic          empty_next_c;
    logic          almost_empty_next_c;
    logic          underflow_next_c;

    // Next-state evaluation; pops are gated by the registered empty flag.
    always_comb begin
        pop_c               = 1'b0;
        raddr_next_c        = raddr;
        rptr_next_c         = rptr;
        wbin_c              = '0;
        rcount_next_c       = '0;
        empty_next_c        = 1'b1;
        almost_empty_next_c = 1'b1;
        underflow_next_c    = underflow;

        pop_c               = bus.r_en & ~empty;
        raddr_next_c        = raddr + PW'(pop_c);
        rptr_next_c         = PW'(bin2gray(GRAY_MAX_W'(raddr_next_c)));
        wbin_c              = PW'(gray2bin(GRAY_MAX_W'(bus.wptr_sync)));
        rcount_next_c       = wbin_c - raddr_next_c;
        empty_next_c        = (rptr_next_c == bus.wptr_sync);
        almost_empty_next_c = (rcount_next_c <= PW'(AE_THRESH));
        underflow_next_c    = underflow | (bus.r_en & empty);
    end

    always_ff @(posedge rclk) begin
        if (!r_rst_n) begin
            raddr        <= '0;
            rptr         <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rcount       <= '0;
            rvalid       <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            raddr        <= raddr_next_c;
            rptr         <= rptr_next_c;
            empty        <= empty_next_c;
            almost_empty <= almost_empty_next_c;
            rcount       <= rcount_next_c;
            rvalid       <= pop_c;
            underflow    <= underflow_next_c;
        end
    end

    assign bus.raddr        = raddr;
    assign bus.rptr         = rptr;
    assign bus.empty        = empty;
    assign bus.almost_empty = almost_empty;
    assign bus.rcount       = rcount;
    assign bus.rvalid       = rvalid;
    assign bus.underflow    = underflow;

endmodule

// File: tb/tb_read_ptr.sv
// Directed bench for read_ptr (ptr_width=3, AE_THRESH=2) with a queue-based scoreboard.
module tb_read_ptr;

    typedef struct packed {
        logic [3:0] raddr;
        logic [3:0] rptr;
        logic [3:0] rcount;
        logic       empty;
        logic       ae;
        logic       rvalid;
        logic       under;
    } exp_t;

    logic rclk;
    logic r_rst_n;

    read_ptr_if #(.ptr_width(3)) bus ();

    read_ptr #(.ptr_width(3), .AE_THRESH(2)) dut (
        .rclk   (rclk),
        .r_rst_n(r_rst_n),
        .bus    (bus.slave)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t m;
    exp_t sb_q[$];
    logic [3:0] gtab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                              4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Predict the post-edge state, queue it, apply inputs, then compare after the edge.
    task automatic step(input logic en, input logic [3:0] w, input logic rst);
        exp_t e;
        exp_t got;
        logic pop;
        logic [3:0] wbin;
        if (!rst) begin
            e = '{raddr: 4'd0, rptr: 4'd0, rcount: 4'd0, empty: 1'b1, ae: 1'b1,
                  rvalid: 1'b0, under: 1'b0};
        end else begin
            pop  = en & ~m.empty;
            wbin = 4'd0;
            for (int i = 0; i < 16; i++) if (gtab[i] == w) wbin = 4'(i);
            e.raddr  = m.raddr + 4'(pop);
            e.rptr   = gtab[e.raddr];
            e.empty  = (e.rptr == w);
            e.rcount = wbin - e.raddr;
            e.ae     = (e.rcount <= 4'd2);
            e.rvalid = pop;
            e.under  = m.under | (en & m.empty);
        end
        m = e;
        sb_q.push_back(e);
        bus.r_en      = en;
        bus.wptr_sync = w;
        r_rst_n       = rst;
        @(posedge rclk);
        #1;
        got = sb_q.pop_front();
        chk("raddr",        32'(bus.raddr),        32'(got.raddr));
        chk("rptr",         32'(bus.rptr),         32'(got.rptr));
        chk("rcount",       32'(bus.rcount),       32'(got.rcount));
        chk("empty",        32'(bus.empty),        32'(got.empty));
        chk("almost_empty", 32'(bus.almost_empty), 32'(got.ae));
        chk("rvalid",       32'(bus.rvalid),       32'(got.rvalid));
        chk("underflow",    32'(bus.underflow),    32'(got.under));
    endtask

    initial begin
        int         rv_cnt;
        logic [3:0] w;
        logic [3:0] prev_raddr;
        logic [3:0] prev_rptr;
        logic       saw_addr_wrap;
        logic       saw_ptr_wrap;

        m = '0;
        r_rst_n       = 1'b0;
        bus.r_en      = 1'b1;
        bus.wptr_sync = 4'b0111;

        // Reset with pop request and a non-zero write pointer present
        step(1'b1, 4'b0111, 1'b0);
        step(1'b1, 4'b0111, 1'b0);
        chk("rst_raddr", 32'(bus.raddr), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_ae",    32'(bus.almost_empty), 32'd1);

        // Fill: five words visible
        step(1'b0, 4'b0111, 1'b1);
        chk("fill_rcount", 32'(bus.rcount), 32'd5);
        chk("fill_empty",  32'(bus.empty), 32'd0);
        chk("fill_ae",     32'(bus.almost_empty), 32'd0);

        // Drain with five back-to-back pops
        rv_cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 4'b0111, 1'b1);
            rv_cnt += int'(bus.rvalid);
            chk("drain_raddr", 32'(bus.raddr), 32'(i));
            if (i == 3) chk("drain_ae_at2", 32'(bus.almost_empty), 32'd1);
            if (i == 4) chk("drain_not_empty", 32'(bus.empty), 32'd0);
        end
        chk("drain_empty", 32'(bus.empty), 32'd1);
        chk("drain_rptr",  32'(bus.rptr), 32'b0111);
        step(1'b0, 4'b0111, 1'b1);
        rv_cnt += int'(bus.rvalid);
        step(1'b0, 4'b0111, 1'b1);
        rv_cnt += int'(bus.rvalid);
        chk("drain_rvalid_cycles", 32'(rv_cnt), 32'd5);

        // Underflow: single pop attempt while empty, then hold
        step(1'b1, 4'b0111, 1'b1);
        chk("uf_raddr",  32'(bus.raddr), 32'd5);
        chk("uf_rvalid", 32'(bus.rvalid), 32'd0);
        chk("uf_set",    32'(bus.underflow), 32'd1);
        for (int i = 0; i < 10; i++) step(1'b0, 4'b0111, 1'b1);
        chk("uf_sticky", 32'(bus.underflow), 32'd1);

        // Wrap: sixteen write/pop pairs starting from raddr=5
        saw_addr_wrap = 1'b0;
        saw_ptr_wrap  = 1'b0;
        for (int k = 6; k <= 21; k++) begin
            w = gtab[k % 16];
            for (int p = 0; p < 2; p++) begin
                prev_raddr = bus.raddr;
                prev_rptr  = bus.rptr;
                step(logic'(p), w, 1'b1);
                if (prev_raddr == 4'd15 && bus.raddr == 4'd0) saw_addr_wrap = 1'b1;
                if (prev_rptr == 4'b1000 && bus.rptr == 4'b0000) saw_ptr_wrap = 1'b1;
                chk("wrap_empty_eq", 32'(bus.empty), 32'(bus.rptr == w));
                chk("wrap_rcount_le8", 32'(bus.rcount <= 4'd8), 32'd1);
            end
        end
        chk("wrap_raddr_15_0", 32'(saw_addr_wrap), 32'd1);
        chk("wrap_rptr_8_0",   32'(saw_ptr_wrap), 32'd1);

        // Full occupancy from raddr=0
        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b1100, 1'b1);
        chk("full_rcount", 32'(bus.rcount), 32'd8);
        chk("full_empty",  32'(bus.empty), 32'd0);
        chk("full_ae",     32'(bus.almost_empty), 32'd0);
        step(1'b1, 4'b1100, 1'b1);
        chk("full_pop_rcount", 32'(bus.rcount), 32'd7);
        chk("full_pop_rptr",   32'(bus.rptr), 32'b0001);

        // Reset in the middle of a four-pop burst, then resume
        step(1'b1, 4'b1100, 1'b1);
        step(1'b1, 4'b1100, 1'b0);
        chk("mid_rst_raddr",  32'(bus.raddr), 32'd0);
        chk("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
        step(1'b0, 4'b1100, 1'b1);
        chk("resume_rvalid", 32'(bus.rvalid), 32'd0);
        step(1'b1, 4'b1100, 1'b1);
        step(1'b1, 4'b1100, 1'b1);
        chk("resume_raddr",  32'(bus.raddr), 32'd2);
        chk("resume_rvalid", 32'(bus.rvalid), 32'd1);
        chk("resume_rcount", 32'(bus.rcount), 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
